alg_sample_sequencer: RTL



---
 rtl/alg_sample_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alg_sample_sequencer.sv
// alg_sample_sequencer
// Sits between the incoming-sample FIFO and the moving-average detection
// datapath. A start command begins a run of sample_count samples. Each sample
// is popped from the FIFO and has the zero-centerline offset removed. It is
// then offered to the datapath over a valid/ready handshake. The block tracks
// the sample index, flags when the long moving-average window has filled, and
// pulses done at the end of the run.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   start         begin a run (only looked at while idle)
//   abort         end the current run immediately, no done pulse
//   sample_count  samples in the run, captured when start is accepted
//   fifo_empty    sample FIFO has nothing to pop
//   fifo_rdata    FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    FIFO pop strobe (combinational, only in FETCH)
//   out_valid     out_data holds a sample for the datapath
//   out_ready     datapath accepts the sample
//   out_data      signed sample, fifo_rdata - DATA_OFFSET (mod 2^DATA_WIDTH)
//   out_warm      long moving-average window is full for this sample
//   sample_idx    0-based index of the current or next sample
//   busy          run in progress
//   done          one-cycle end-of-run pulse
module alg_sample_sequencer #(
    parameter int DATA_WIDTH  = 11,
    parameter int CTR_WIDTH   = 22,
    parameter int DATA_OFFSET = 1024,
    parameter int N_LONG      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CTR_WIDTH-1:0]  sample_count,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_warm,
    output logic [CTR_WIDTH-1:0]  sample_idx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DATA_WIDTH-1:0] OFFSET_C   = DATA_WIDTH'(DATA_OFFSET);
    localparam logic [CTR_WIDTH-1:0]  WARM_IDX_C = CTR_WIDTH'(N_LONG - 1);
    localparam logic [CTR_WIDTH-1:0]  CTR_ONE_C  = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0]  CTR_ZERO_C = {CTR_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CTR_WIDTH-1:0]   count_r;
    logic [CTR_WIDTH-1:0]   count_next_s;
    logic [CTR_WIDTH-1:0]   idx_next_s;
    logic                   load_data_s;
    logic                   warm_next_s;

    // Next-state, counter and FIFO-pop decode; abort overrides everything
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        idx_next_s   = sample_idx;
        load_data_s  = 1'b0;
        fifo_rd_en   = 1'b0;
        if (abort) begin
            // In IDLE this simply keeps the block idle, so abort there is a no-op.
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (sample_count != CTR_ZERO_C) begin
                            count_next_s = sample_count;
                            idx_next_s   = CTR_ZERO_C;
                            state_next_s = ST_FETCH;
                        end else begin
                            state_next_s = ST_DONE;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        fifo_rd_en   = 1'b1;
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    load_data_s  = 1'b1;
                    state_next_s = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        if (sample_idx == (count_r - CTR_ONE_C)) begin
                            state_next_s = ST_DONE;
                        end else begin
                            idx_next_s   = sample_idx + CTR_ONE_C;
                            state_next_s = ST_FETCH;
                        end
                    end else begin
                        state_next_s = ST_PRESENT;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // The index does not change on entry to PRESENT or while there, so the next index decides warm-up.
    always_comb begin
        warm_next_s = 1'b0;
        if (state_next_s == ST_PRESENT) begin
            warm_next_s = (idx_next_s >= WARM_IDX_C);
        end else begin
            warm_next_s = 1'b0;
        end
    end

    // State, run length and index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            count_r    <= CTR_ZERO_C;
            sample_idx <= CTR_ZERO_C;
        end else begin
            state_r    <= state_next_s;
            count_r    <= count_next_s;
            sample_idx <= idx_next_s;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_warm  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= (state_next_s == ST_PRESENT);
            out_warm  <= warm_next_s;
            busy      <= (state_next_s != ST_IDLE);
            done      <= (state_next_s == ST_DONE);
        end
    end

    // Offset-corrected sample capture. An abort in WAIT leaves load_data_s low,
    // so the popped sample is dropped. The subtraction wraps, giving two's complement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= {DATA_WIDTH{1'b0}};
        end else if (load_data_s) begin
            out_data <= fifo_rdata - OFFSET_C;
        end else begin
            out_data <= out_data;
        end
    end

endmodule
